// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_W       : architectural register-index width (8 registers)
//   hz_state_t  : hazard-controller state encoding
//   fwd_sel_t   : operand forwarding select (FWD_RF / FWD_EX / FWD_MEM)
package cpu_pkg;

    localparam int REG_W = 3;

    typedef enum logic [2:0] {
        RESET_IDLE = 3'd0,
        RUN        = 3'd1,
        MEM_WAIT   = 3'd2,
        DRAIN      = 3'd3,
        HALTED     = 3'd4
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding compare for one ID source operand.
//   src           : register index read by the ID instruction
//   ex_write_reg  : instruction in EX writes a register
//   ex_read_mem   : instruction in EX is a load (its data is not ready in EX)
//   ex_dst        : EX destination register
//   mem_write_reg : instruction in MEM writes a register
//   mem_dst       : MEM destination register
//   sel           : FWD_EX, FWD_MEM or FWD_RF; the younger EX result wins
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int W = REG_W
) (
    input  logic [W-1:0] src,
    input  logic         ex_write_reg,
    input  logic         ex_read_mem,
    input  logic [W-1:0] ex_dst,
    input  logic         mem_write_reg,
    input  logic [W-1:0] mem_dst,
    output fwd_sel_t     sel
);

    // Select the youngest in-flight producer of src.
    always_comb begin
        sel = FWD_RF;
        if (ex_write_reg && !ex_read_mem && (ex_dst == src)) begin
            sel = FWD_EX;
        end else if (mem_write_reg && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / forward controller for the 5-stage (IF ID EX MEM WB) core.
// Inputs : ID source fields and halt flag, ID_EX and EX_MEM control bits,
//          data-memory ack and the EX branch outcome.
// Outputs: pc_en / if_id_en / id_ex_en / ex_mem_en register enables,
//          if_id_flush / id_ex_bubble / mem_wb_bubble NOP loads,
//          fwd_a / fwd_b operand selects, halted, sticky mem_timeout and
//          a saturating stall_cnt.
// Enables, bubbles and forward selects are decoded combinationally from
// the state and the current inputs; state and counters are registered.
module pipe_hazard_ctrl #(
    parameter int REG_W        = cpu_pkg::REG_W,
    parameter int MEM_WAIT_MAX = 15,
    parameter int DRAIN_CYC    = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_reg1,
    input  logic [REG_W-1:0] id_reg2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_halt,
    input  logic             ex_write_reg,
    input  logic             ex_read_mem,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_branch_taken,
    input  logic             mem_write_reg,
    input  logic             mem_read_mem,
    input  logic             mem_write_mem,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYC + 1);

    // Last wait_cnt value that may still be extended; reaching it with ack
    // still low means MEM_WAIT_MAX low-ack cycles have elapsed.
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
    localparam logic [DRN_W-1:0]  DRAIN_INIT = DRN_W'(DRAIN_CYC);
    localparam logic [DRN_W-1:0]  DRN_ONE    = DRN_W'(1);
    localparam logic [DRN_W-1:0]  DRN_ZERO   = {DRN_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    cpu_pkg::hz_state_t state_r;
    cpu_pkg::hz_state_t state_nx_s;
    cpu_pkg::hz_state_t run_state_s;

    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_nx_s;
    logic [WAIT_W-1:0] run_wait_s;
    logic [DRN_W-1:0]  drain_cnt_r;
    logic [DRN_W-1:0]  drain_nx_s;
    logic [DRN_W-1:0]  run_drain_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              halted_r;
    logic              mem_timeout_r;
    logic              tmo_nx_s;

    // Enable vectors are ordered {pc, if_id, id_ex, ex_mem}.
    logic [3:0] en_s;
    logic [3:0] run_en_s;
    logic       flush_s;
    logic       bub_s;
    logic       wbb_s;
    logic       run_flush_s;
    logic       run_bub_s;
    logic       run_wbb_s;

    logic       mem_busy_s;
    logic       load_use_s;
    logic       stall_inc_s;
    logic [1:0] fwd_a_raw_s;
    logic [1:0] fwd_b_raw_s;

    fwd_unit #(.W(REG_W)) u_fwd_a (
        .src           (id_reg1),
        .ex_write_reg  (ex_write_reg),
        .ex_read_mem   (ex_read_mem),
        .ex_dst        (ex_dst),
        .mem_write_reg (mem_write_reg),
        .mem_dst       (mem_dst),
        .sel           (fwd_a_raw_s)
    );

    fwd_unit #(.W(REG_W)) u_fwd_b (
        .src           (id_reg2),
        .ex_write_reg  (ex_write_reg),
        .ex_read_mem   (ex_read_mem),
        .ex_dst        (ex_dst),
        .mem_write_reg (mem_write_reg),
        .mem_dst       (mem_dst),
        .sel           (fwd_b_raw_s)
    );

    // Raw hazard conditions.
    always_comb begin
        mem_busy_s = (mem_read_mem | mem_write_mem) & ~mem_ack;
        load_use_s = ex_read_mem & ex_write_reg &
                     ((id_use1 & (ex_dst == id_reg1)) |
                      (id_use2 & (ex_dst == id_reg2)));
    end

    // RUN priority chain; also reused for the MEM_WAIT cycle in which ack arrives.
    always_comb begin
        run_en_s    = 4'b1111;
        run_flush_s = 1'b0;
        run_bub_s   = 1'b0;
        run_wbb_s   = 1'b0;
        run_state_s = cpu_pkg::RUN;
        run_wait_s  = WAIT_ZERO;
        run_drain_s = drain_cnt_r;
        if (mem_busy_s) begin
            run_en_s    = 4'b0000;
            run_wbb_s   = 1'b1;
            run_state_s = cpu_pkg::MEM_WAIT;
            run_wait_s  = WAIT_ONE;
        end else if (ex_branch_taken) begin
            // Wrong-path instructions in IF_ID and ID are squashed; a
            // load-use or HALT seen in ID belongs to that wrong path.
            run_flush_s = 1'b1;
            run_bub_s   = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF_ID one cycle; ID_EX takes a bubble so the load
            // moves to MEM and is forwarded from there next cycle.
            run_en_s  = 4'b0011;
            run_bub_s = 1'b1;
        end else if (id_halt) begin
            run_state_s = cpu_pkg::DRAIN;
            run_drain_s = DRAIN_INIT;
        end else begin
            run_en_s = 4'b1111;
        end
    end

    // Per-state output decode and next-state / next-counter selection.
    always_comb begin
        en_s       = 4'b0000;
        flush_s    = 1'b1;
        bub_s      = 1'b1;
        wbb_s      = 1'b1;
        state_nx_s = state_r;
        wait_nx_s  = wait_cnt_r;
        drain_nx_s = drain_cnt_r;
        tmo_nx_s   = mem_timeout_r;
        case (state_r)
            cpu_pkg::RESET_IDLE: begin
                state_nx_s = cpu_pkg::RUN;
                wait_nx_s  = WAIT_ZERO;
                drain_nx_s = DRN_ZERO;
            end
            cpu_pkg::RUN: begin
                en_s       = run_en_s;
                flush_s    = run_flush_s;
                bub_s      = run_bub_s;
                wbb_s      = run_wbb_s;
                state_nx_s = run_state_s;
                wait_nx_s  = run_wait_s;
                drain_nx_s = run_drain_s;
            end
            cpu_pkg::MEM_WAIT: begin
                if (mem_ack) begin
                    en_s       = run_en_s;
                    flush_s    = run_flush_s;
                    bub_s      = run_bub_s;
                    wbb_s      = run_wbb_s;
                    state_nx_s = run_state_s;
                    wait_nx_s  = run_wait_s;
                    drain_nx_s = run_drain_s;
                end else begin
                    flush_s = 1'b0;
                    bub_s   = 1'b0;
                    if (wait_cnt_r >= WAIT_LAST) begin
                        tmo_nx_s   = 1'b1;
                        state_nx_s = cpu_pkg::HALTED;
                    end else begin
                        wait_nx_s = wait_cnt_r + WAIT_ONE;
                    end
                end
            end
            cpu_pkg::DRAIN: begin
                if (mem_busy_s) begin
                    // Freeze exactly like MEM_WAIT; drain_cnt holds.
                    flush_s = 1'b0;
                    bub_s   = 1'b0;
                    if (wait_cnt_r >= WAIT_LAST) begin
                        tmo_nx_s   = 1'b1;
                        state_nx_s = cpu_pkg::HALTED;
                    end else begin
                        wait_nx_s = wait_cnt_r + WAIT_ONE;
                    end
                end else begin
                    en_s       = 4'b0011;
                    flush_s    = 1'b0;
                    bub_s      = 1'b1;
                    wbb_s      = 1'b0;
                    wait_nx_s  = WAIT_ZERO;
                    drain_nx_s = drain_cnt_r - DRN_ONE;
                    if (drain_cnt_r <= DRN_ONE) begin
                        state_nx_s = cpu_pkg::HALTED;
                    end else begin
                        state_nx_s = cpu_pkg::DRAIN;
                    end
                end
            end
            cpu_pkg::HALTED: begin
                state_nx_s = cpu_pkg::HALTED;
            end
            default: begin
                // Corrupted state encoding: park safely with everything frozen.
                state_nx_s = cpu_pkg::HALTED;
            end
        endcase
    end

    // Count cycles in which the PC is held while the core is live.
    always_comb begin
        if ((state_r == cpu_pkg::RUN) || (state_r == cpu_pkg::MEM_WAIT) ||
            (state_r == cpu_pkg::DRAIN)) begin
            stall_inc_s = ~en_s[3] & (stall_cnt_r != CNT_MAX);
        end else begin
            stall_inc_s = 1'b0;
        end
    end

    // State, counters and sticky status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= cpu_pkg::RESET_IDLE;
            wait_cnt_r    <= WAIT_ZERO;
            drain_cnt_r   <= DRN_ZERO;
            stall_cnt_r   <= CNT_ZERO;
            halted_r      <= 1'b0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            wait_cnt_r    <= wait_nx_s;
            drain_cnt_r   <= drain_nx_s;
            mem_timeout_r <= tmo_nx_s;
            halted_r      <= (state_nx_s == cpu_pkg::HALTED);
            if (stall_inc_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign pc_en         = en_s[3];
    assign if_id_en      = en_s[2];
    assign id_ex_en      = en_s[1];
    assign ex_mem_en     = en_s[0];
    assign if_id_flush   = flush_s;
    assign id_ex_bubble  = bub_s;
    assign mem_wb_bubble = wbb_s;
    // Selects read as register file while the pipeline is still being reset.
    assign fwd_a         = (state_r == cpu_pkg::RESET_IDLE) ? cpu_pkg::FWD_RF : fwd_a_raw_s;
    assign fwd_b         = (state_r == cpu_pkg::RESET_IDLE) ? cpu_pkg::FWD_RF : fwd_b_raw_s;
    assign halted        = halted_r;
    assign mem_timeout   = mem_timeout_r;
    assign stall_cnt     = stall_cnt_r;

endmodule
